// File: rtl/maze_map_server.sv
// Tile-map server: two 3-stage read ports over a shared 2-bit tile RAM, a power-up map builder,
// and an optional ball overlay on port B (enabled by defining MAZE_MAP_BALL_OVERLAY_EN).
module maze_map_server #(
  parameter int          TILE_COLS = 40,
  parameter int          TILE_ROWS = 30,
  parameter logic [7:0]  FLOOR_PX  = 8'h00,
  parameter logic [7:0]  WALL_PX   = 8'h26,
  parameter logic [7:0]  HOLE_PX   = 8'h49,
  parameter logic [7:0]  WIN_PX    = 8'hF9,
  parameter logic [7:0]  BALL_PX   = 8'hFF,
  parameter int          BALL_HALF = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] a_col_addr,
  input  logic [9:0] a_row_addr,
  output logic [7:0] a_out,
  input  logic [9:0] b_col_addr,
  input  logic [9:0] b_row_addr,
  output logic [7:0] b_out,
  input  logic       wr_en,
  input  logic [5:0] wr_tile_col,
  input  logic [4:0] wr_tile_row,
  input  logic [1:0] wr_tile,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       ready
);

  localparam int          NTILES     = TILE_COLS * TILE_ROWS;
  localparam logic [10:0] COL_PX_LIM = 11'(TILE_COLS * 16);
  localparam logic [10:0] ROW_PX_LIM = 11'(TILE_ROWS * 16);
  localparam logic [10:0] LAST_IDX   = 11'(NTILES - 1);
  localparam logic [5:0]  LAST_COL   = 6'(TILE_COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(TILE_ROWS - 1);
  localparam logic [6:0]  NCOLS      = 7'(TILE_COLS);
  localparam logic [5:0]  NROWS      = 6'(TILE_ROWS);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [7:0] class_code(input logic [1:0] cls);
    logic [7:0] code;
    case (cls)
      2'd0:    code = FLOOR_PX;
      2'd1:    code = WALL_PX;
      2'd2:    code = HOLE_PX;
      default: code = WIN_PX;
    endcase
    return code;
  endfunction

  function automatic logic [10:0] tile_index(input logic [5:0] col, input logic [5:0] row);
    return 11'(row) * 11'(TILE_COLS) + 11'(col);
  endfunction

  function automatic logic in_map(input logic [9:0] col, input logic [9:0] row);
    return ({1'b0, col} < COL_PX_LIM) && ({1'b0, row} < ROW_PX_LIM);
  endfunction

  logic [1:0]  tile_mem_q [NTILES];

  state_t      state_q, state_d;
  logic [10:0] init_idx_q, init_idx_d;
  logic [5:0]  init_col_q, init_col_d;
  logic [4:0]  init_row_q, init_row_d;
  logic        ready_q, ready_d;
  logic        init_we;
  logic [1:0]  init_cls;

  logic        usr_we_q, usr_we_d;
  logic [10:0] usr_idx_q, usr_idx_d;
  logic [1:0]  usr_cls_q;

  logic [10:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d;
  logic        a_inr_q, b_inr_q, a_rdy_q, b_rdy_q, b_ball_q;
  logic [1:0]  a_cls_q, b_cls_q;
  logic        a_inr2_q, b_inr2_q, a_rdy2_q, b_rdy2_q, b_ball2_q;
  logic [7:0]  a_out_q, a_out_d, b_out_q, b_out_d;
  logic        a_inr, b_inr, ball_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= 11'd0;
      init_col_q <= 6'd0;
      init_row_q <= 5'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      init_col_q <= init_col_d;
      init_row_q <= init_row_d;
      ready_q    <= ready_d;
    end
  end

  // Map builder walks the tiles in raster order; the border ring becomes wall.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_col_d = init_col_q;
    init_row_d = init_row_q;
    ready_d    = 1'b0;
    init_we    = 1'b0;
    init_cls   = 2'd0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if ((init_row_q == 5'd0) || (init_row_q == LAST_ROW) ||
            (init_col_q == 6'd0) || (init_col_q == LAST_COL)) begin
          init_cls = 2'd1;
        end else begin
          init_cls = 2'd0;
        end
        if (init_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          init_idx_d = init_idx_q + 11'd1;
          if (init_col_q == LAST_COL) begin
            init_col_d = 6'd0;
            init_row_d = init_row_q + 5'd1;
          end else begin
            init_col_d = init_col_q + 6'd1;
          end
        end
      end
      ST_RUN:  ready_d = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Host writes are staged one cycle so they land alongside the RAM read of reads issued
  // in the same cycle, which therefore see the old contents.
  always_comb begin
    usr_we_d  = wr_en && ready_q && ({1'b0, wr_tile_col} < NCOLS) && ({1'b0, wr_tile_row} < NROWS);
    usr_idx_d = tile_index(wr_tile_col, {1'b0, wr_tile_row});
    a_inr     = in_map(a_col_addr, a_row_addr);
    b_inr     = in_map(b_col_addr, b_row_addr);
    a_idx_d   = a_inr ? tile_index(a_col_addr[9:4], a_row_addr[9:4]) : 11'd0;
    b_idx_d   = b_inr ? tile_index(b_col_addr[9:4], b_row_addr[9:4]) : 11'd0;
  end

`ifdef MAZE_MAP_BALL_OVERLAY_EN
  localparam logic signed [10:0] BH = 11'(BALL_HALF);
  logic signed [10:0] ball_dx, ball_dy;
  assign ball_dx  = $signed({1'b0, b_col_addr}) - $signed({1'b0, ball_x});
  assign ball_dy  = $signed({1'b0, b_row_addr}) - $signed({1'b0, ball_y});
  assign ball_hit = (ball_dx <= BH) && (ball_dx >= -BH) && (ball_dy <= BH) && (ball_dy >= -BH);
`else
  logic unused_ball;
  assign unused_ball = ^{ball_x, ball_y};
  assign ball_hit    = 1'b0;
`endif

  // The RAM itself is not reset; the map builder rewrites every entry after reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      tile_mem_q[init_idx_q] <= init_cls;
    end else if (usr_we_q) begin
      tile_mem_q[usr_idx_q] <= usr_cls_q;
    end
  end

  // Output mapping: not-ready forces wall, then ball, then out-of-map wall, then tile class.
  always_comb begin
    a_out_d = WALL_PX;
    b_out_d = WALL_PX;
    if (a_rdy2_q && a_inr2_q) begin
      a_out_d = class_code(a_cls_q);
    end else begin
      a_out_d = WALL_PX;
    end
    if (!b_rdy2_q) begin
      b_out_d = WALL_PX;
    end else if (b_ball2_q) begin
      b_out_d = BALL_PX;
    end else if (!b_inr2_q) begin
      b_out_d = WALL_PX;
    end else begin
      b_out_d = class_code(b_cls_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      usr_we_q  <= 1'b0;  usr_idx_q <= 11'd0;  usr_cls_q <= 2'd0;
      a_idx_q   <= 11'd0; a_inr_q   <= 1'b0;   a_rdy_q   <= 1'b0;
      b_idx_q   <= 11'd0; b_inr_q   <= 1'b0;   b_rdy_q   <= 1'b0; b_ball_q <= 1'b0;
      a_cls_q   <= 2'd0;  a_inr2_q  <= 1'b0;   a_rdy2_q  <= 1'b0;
      b_cls_q   <= 2'd0;  b_inr2_q  <= 1'b0;   b_rdy2_q  <= 1'b0; b_ball2_q <= 1'b0;
      a_out_q   <= WALL_PX;
      b_out_q   <= WALL_PX;
    end else begin
      usr_we_q  <= usr_we_d;  usr_idx_q <= usr_idx_d; usr_cls_q <= wr_tile;
      a_idx_q   <= a_idx_d;   a_inr_q   <= a_inr;     a_rdy_q   <= ready_q;
      b_idx_q   <= b_idx_d;   b_inr_q   <= b_inr;     b_rdy_q   <= ready_q; b_ball_q <= ball_hit;
      a_cls_q   <= tile_mem_q[a_idx_q]; a_inr2_q <= a_inr_q; a_rdy2_q <= a_rdy_q;
      b_cls_q   <= tile_mem_q[b_idx_q]; b_inr2_q <= b_inr_q; b_rdy2_q <= b_rdy_q;
      b_ball2_q <= b_ball_q;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
    end
  end

  assign a_out = a_out_q;
  assign b_out = b_out_q;
  assign ready = ready_q;

endmodule

// File: doc/maze_map_server.md
MAZE_MAP_SERVER -- requirements
Module: maze_map_server

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter TILE_COLS, default 40, SHALL give the map width in 16x16-pixel tiles.
REQ-003 Parameter TILE_ROWS, default 30, SHALL give the map height in tiles.
REQ-004 Parameters FLOOR_PX, WALL_PX, HOLE_PX, WIN_PX, with defaults 8'h00, 8'h26, 8'h49, 8'hF9, SHALL give the pixel code returned for each tile class.
REQ-005 Parameter BALL_PX, default 8'hFF, SHALL give the ball overlay pixel code.
REQ-006 Parameter BALL_HALF, default 7, SHALL give the ball overlay half-width in pixels.
REQ-007 The ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- a_col_addr  in  10  collision-port pixel column
- a_row_addr  in  10  collision-port pixel row
- a_out  out  8  collision-port pixel code
- b_col_addr  in  10  video-port pixel column
- b_row_addr  in  10  video-port pixel row
- b_out  out  8  video-port pixel code
- wr_en  in  1  tile write strobe
- wr_tile_col  in  6  tile column to write
- wr_tile_row  in  5  tile row to write
- wr_tile  in  2  tile class: 0 floor, 1 wall, 2 hole, 3 win
- ball_x  in  10  ball centre column (overlay)
- ball_y  in  10  ball centre row (overlay)
- ready  out  1  map initialised, writes accepted

Function
REQ-008 Tile storage SHALL be TILE_COLS*TILE_ROWS entries of 2 bits, indexed by tile_row*TILE_COLS+tile_col with an 11-bit index.
REQ-009 The tile coordinate of a pixel address SHALL be addr[9:4].
REQ-010 Port A SHALL have a fixed 3-cycle latency:
- cycle 1: register the address and the range check;
- cycle 2: read the tile RAM;
- cycle 3: register the class-to-code map into a_out.
REQ-011 Port A SHALL accept a new address every cycle, fully pipelined with no stall.
REQ-012 Port B SHALL use the same 3-stage pipeline, operate independently of port A, and share the tile RAM (dual read).
REQ-013 An address with col >= TILE_COLS*16 or row >= TILE_ROWS*16 SHALL return WALL_PX on either port.
REQ-014 The class-to-code map SHALL be 0->FLOOR_PX, 1->WALL_PX, 2->HOLE_PX, 3->WIN_PX.
REQ-015 The init FSM SHALL have two states, INIT and RUN.
REQ-016 In INIT the FSM SHALL write one tile per cycle, for index 0 to 1199:
- wall if tile_row is 0 or TILE_ROWS-1, or tile_col is 0 or TILE_COLS-1;
- floor otherwise.
REQ-017 INIT SHALL then go to RUN and set ready=1 on the cycle after the last tile write.
REQ-018 While ready=0, wr_en SHALL be ignored, and both ports SHALL return WALL_PX regardless of RAM contents.
REQ-019 In RUN, wr_en=1 SHALL write wr_tile to the addressed tile at the clock edge.
REQ-020 A write with wr_tile_col >= TILE_COLS or wr_tile_row >= TILE_ROWS SHALL be dropped.
REQ-021 A read and a write to the same tile in the same cycle SHALL return the old contents (read-first); the new value SHALL be visible to reads issued one cycle later.
REQ-022 The ball overlay (when compiled in) SHALL be evaluated in stage 1 and pipelined alongside the port-B address, so that b_out latency stays 3 cycles.

Reset
REQ-023 On reset the block SHALL set a_out=WALL_PX, b_out=WALL_PX and ready=0, clear the pipeline registers, enter INIT with the index at 0, and flush pipeline valid.
REQ-024 Reset asserted mid-INIT or in RUN SHALL restart INIT from index 0, overwriting any tiles written earlier.

Configuration
REQ-025 Macro MAZE_MAP_BALL_OVERLAY_EN SHALL control the ball overlay.
- Defined: port B SHALL return BALL_PX when |b_col_addr-ball_x| <= BALL_HALF and |b_row_addr-ball_y| <= BALL_HALF, using signed 11-bit differences. This SHALL take precedence over the tile and out-of-range codes, but SHALL NOT override the WALL_PX forced while ready=0.
- Not defined: ball_x and ball_y SHALL be unused, and port B SHALL be pixel-identical to port A's mapping.
- Port A SHALL never show the ball in either case.

Verification
REQ-026 Reset for 1 cycle, then idle: ready SHALL rise exactly 1201 cycles after reset deasserts; port A reads before then SHALL return 8'h26.
REQ-027 After ready, port A at (0,0) -> 8'h26 and at (320,240) -> 8'h00, each 3 cycles after the address is presented; back-to-back reads on consecutive cycles -> consecutive results.
REQ-028 Write tile (10,5)=2, then read port A at col 165, row 85 -> 8'h49 at cycle +3; a same-cycle read of that tile -> 8'h00.
REQ-029 Port A col 700 row 10 -> 8'h26; port B row 480 -> 8'h26; write to tile (45,3) -> no change at (45*16 mod, i.e. no RAM effect).
REQ-030 Write tiles, then assert reset at INIT index 600: ready SHALL stay low until 1201 cycles after the new reset, and the written tiles SHALL read as floor.
REQ-031 With overlay enabled, ball=(100,100): port B at (107,93) -> 8'hFF, at (108,100) -> 8'h00, port A at (100,100) -> 8'h00; with overlay disabled, port B at (100,100) -> 8'h00.
